// File: rtl/uart_rx_ctrl.sv
// Receive-side buffer between a UART receiver and a host: byte FIFO with
// overrun/timeout status and a level/error interrupt.
module uart_rx_ctrl #(
   parameter int DEPTH        = 4,
   parameter int TIMEOUT_CLKS = 1000
) (
   input  logic                     in_Clk,
   input  logic                     in_Reset,
   input  logic                     in_Enable,
   input  logic                     in_RX_DV,
   input  logic [7:0]               in_RX_Byte,
   input  logic                     in_Rd_En,
   input  logic                     in_Clr_Ovr,
   input  logic [$clog2(DEPTH):0]   in_Thresh,
   output logic [7:0]               out_Rd_Data,
   output logic                     out_Rd_Valid,
   output logic [$clog2(DEPTH):0]   out_Count,
   output logic                     out_Empty,
   output logic                     out_Full,
   output logic                     out_Overrun,
   output logic                     out_Timeout,
   output logic                     out_IRQ
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CLKS);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic {ST_DISABLED = 1'b0, ST_ACTIVE = 1'b1} state_t;

   state_t          state_r;
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [TW-1:0]   tcnt_r;
   logic [7:0]      mem_r [DEPTH];

   logic            active_s;
   logic            pop_ok_s;
   logic            push_ok_s;
   logic            drop_s;
   logic [CW-1:0]   count_nxt_s;
   logic [TW-1:0]   tcnt_nxt_s;
   logic            ovr_nxt_s;
   logic            to_nxt_s;
   logic            irq_nxt_s;

   // Accept/drop decisions and next-state values for counters and flags
   always_comb begin
      active_s    = (state_r == ST_ACTIVE) && in_Enable;
      pop_ok_s    = active_s && in_Rd_En && (out_Count != {CW{1'b0}});
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      push_ok_s   = active_s && in_RX_DV && ((out_Count != DEPTH_C) || pop_ok_s);
      drop_s      = active_s && in_RX_DV && !push_ok_s;
      count_nxt_s = out_Count;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_nxt_s = out_Count + 1'b1;
         2'b01:   count_nxt_s = out_Count - 1'b1;
         default: count_nxt_s = out_Count;
      endcase
      if (push_ok_s || pop_ok_s || (out_Count == {CW{1'b0}})) begin
         tcnt_nxt_s = {TW{1'b0}};
      end else if (tcnt_r == TO_MAX) begin
         tcnt_nxt_s = tcnt_r;
      end else begin
         tcnt_nxt_s = tcnt_r + 1'b1;
      end
      if (pop_ok_s) begin
         to_nxt_s = 1'b0;
      end else if ((tcnt_nxt_s == tcnt_r) && (tcnt_r == TO_MAX) && active_s) begin
         to_nxt_s = 1'b1;
      end else begin
         to_nxt_s = out_Timeout;
      end
      if (drop_s) begin
         ovr_nxt_s = 1'b1;
      end else if (in_Clr_Ovr) begin
         ovr_nxt_s = 1'b0;
      end else begin
         ovr_nxt_s = out_Overrun;
      end
      irq_nxt_s = active_s &&
                  (((in_Thresh != {CW{1'b0}}) && (count_nxt_s >= in_Thresh)) ||
                   ovr_nxt_s || to_nxt_s);
   end

   // Storage array; contents beyond the pointers are don't-care, so no reset
   always_ff @(posedge in_Clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= in_RX_Byte;
      end
   end

   // Control FSM with all registered outputs
   always_ff @(posedge in_Clk or negedge in_Reset) begin
      if (!in_Reset) begin
         state_r      <= ST_DISABLED;
         wr_ptr_r     <= {AW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         tcnt_r       <= {TW{1'b0}};
         out_Count    <= {CW{1'b0}};
         out_Rd_Data  <= 8'h00;
         out_Rd_Valid <= 1'b0;
         out_Empty    <= 1'b1;
         out_Full     <= 1'b0;
         out_Overrun  <= 1'b0;
         out_Timeout  <= 1'b0;
         out_IRQ      <= 1'b0;
      end else begin
         out_Rd_Valid <= 1'b0;
         out_Overrun  <= ovr_nxt_s;
         out_IRQ      <= irq_nxt_s;
         case (state_r)
            ST_ACTIVE: begin
               if (!in_Enable) begin
                  state_r     <= ST_DISABLED;
                  wr_ptr_r    <= {AW{1'b0}};
                  rd_ptr_r    <= {AW{1'b0}};
                  tcnt_r      <= {TW{1'b0}};
                  out_Count   <= {CW{1'b0}};
                  out_Empty   <= 1'b1;
                  out_Full    <= 1'b0;
                  out_Timeout <= 1'b0;
               end else begin
                  state_r <= ST_ACTIVE;
                  if (push_ok_s) begin
                     wr_ptr_r <= wr_ptr_r + 1'b1;
                  end
                  if (pop_ok_s) begin
                     rd_ptr_r     <= rd_ptr_r + 1'b1;
                     out_Rd_Data  <= mem_r[rd_ptr_r];
                     out_Rd_Valid <= 1'b1;
                  end
                  tcnt_r      <= tcnt_nxt_s;
                  out_Count   <= count_nxt_s;
                  out_Empty   <= (count_nxt_s == {CW{1'b0}});
                  out_Full    <= (count_nxt_s == DEPTH_C);
                  out_Timeout <= to_nxt_s;
               end
            end
            default: begin
               state_r     <= in_Enable ? ST_ACTIVE : ST_DISABLED;
               wr_ptr_r    <= {AW{1'b0}};
               rd_ptr_r    <= {AW{1'b0}};
               tcnt_r      <= {TW{1'b0}};
               out_Count   <= {CW{1'b0}};
               out_Empty   <= 1'b1;
               out_Full    <= 1'b0;
               out_Timeout <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed table-driven bench for uart_rx_ctrl (DEPTH=4, TIMEOUT_CLKS=10).
module tb_uart_rx_ctrl;

   logic       clk_s = 1'b0;
   logic       rst_n_s;
   logic       en_s, dv_s, rd_s, clr_s;
   logic [7:0] din_s;
   logic [2:0] th_s;
   logic [7:0] rdata_s;
   logic       rvalid_s, empty_s, full_s, ovr_s, to_s, irq_s;
   logic [2:0] count_s;

   int tests_run = 0;
   int tests_failed = 0;

   uart_rx_ctrl #(.DEPTH(4), .TIMEOUT_CLKS(10)) dut (
      .in_Clk(clk_s), .in_Reset(rst_n_s), .in_Enable(en_s), .in_RX_DV(dv_s),
      .in_RX_Byte(din_s), .in_Rd_En(rd_s), .in_Clr_Ovr(clr_s), .in_Thresh(th_s),
      .out_Rd_Data(rdata_s), .out_Rd_Valid(rvalid_s), .out_Count(count_s),
      .out_Empty(empty_s), .out_Full(full_s), .out_Overrun(ovr_s),
      .out_Timeout(to_s), .out_IRQ(irq_s)
   );

   always #5 clk_s = ~clk_s;

   // expected packing: {rdata, valid, count, empty, full, ovr, to, irq}
   typedef struct {
      logic       en, dv, rd, clr;
      logic [7:0] din;
      logic [2:0] th;
      logic [16:0] exp;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic en, input logic dv, input logic [7:0] din,
                               input logic rd, input logic clr, input logic [2:0] th,
                               input logic [7:0] rdat, input logic rv, input logic [2:0] cnt,
                               input logic emp, input logic ful, input logic ov,
                               input logic tmo, input logic irq);
      vec_t v;
      v.en = en; v.dv = dv; v.din = din; v.rd = rd; v.clr = clr; v.th = th;
      v.exp = {rdat, rv, cnt, emp, ful, ov, tmo, irq};
      return v;
   endfunction

   task automatic check(input string name, input logic [16:0] exp);
      logic [16:0] act;
      act = {rdata_s, rvalid_s, count_s, empty_s, full_s, ovr_s, to_s, irq_s};
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got {rd,v,cnt,e,f,ovr,to,irq}=%h_%b_%0d_%b%b%b%b%b expected %h_%b_%0d_%b%b%b%b%b",
                  name, act[16:9], act[8], act[7:5], act[4], act[3], act[2], act[1], act[0],
                  exp[16:9], exp[8], exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic tick();
      @(posedge clk_s);
      #1;
   endtask

   task automatic drive(input logic en, input logic dv, input logic [7:0] din,
                        input logic rd, input logic clr, input logic [2:0] th);
      en_s = en; dv_s = dv; din_s = din; rd_s = rd; clr_s = clr; th_s = th;
   endtask

   localparam logic [16:0] RST_EXP = {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      //        en    dv    din    rd    clr   th    rdata  v     cnt   e     f     ovr   to    irq
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'hA5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h3C, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h3C, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h3C, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 3'd0, 8'h3C, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h11, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h11, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h02, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h03, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h04, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h77, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'hCC, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 3'd0, 8'h77, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
      vq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      vq.push_back(mk(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 3'd0, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 3'd2, 8'h77, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 3'd2, 8'h77, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      vq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

      rst_n_s = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
      #12;
      check("reset_values", RST_EXP);
      rst_n_s = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].en, vq[i].dv, vq[i].din, vq[i].rd, vq[i].clr, vq[i].th);
         tick();
         check($sformatf("vec%0d", i), vq[i].exp);
      end

      // idle timeout: flag and IRQ rise after the 10th idle clock, pop clears
      drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 3'd0);
      tick();
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 9; i++) tick();
      check("timeout_idle9", {8'h77, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tick();
      check("timeout_idle10", {8'h77, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      tick();
      check("timeout_hold", {8'h77, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
      tick();
      check("timeout_pop_clear", {8'h5A, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

      // asynchronous reset with bytes queued and a pop request pending
      drive(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 3'd0); tick();
      drive(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0, 3'd0); tick();
      drive(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 3'd0); tick();
      check("reset_seq_queued", {8'h5A, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
      #2;
      rst_n_s = 1'b0;
      #1;
      check("reset_async", RST_EXP);
      @(negedge clk_s);
      rst_n_s = 1'b1;
      tick();
      check("reset_release1", RST_EXP);
      tick();
      check("reset_release2", RST_EXP);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: receive FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CLKS, default 1000: idle clocks with FIFO non-empty before timeout is flagged; minimum 2.
REQ-003 in_Clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 in_Reset  input  1  asynchronous, active-low reset.
REQ-005 in_Enable  input  1  receive enable; low means disabled and flushed.
REQ-006 in_RX_DV  input  1  one-cycle byte-valid strobe from the UART receiver.
REQ-007 in_RX_Byte  input  8  received byte, qualified by in_RX_DV.
REQ-008 in_Rd_En  input  1  host pop request, one byte per asserted cycle.
REQ-009 in_Clr_Ovr  input  1  clears the sticky overrun flag.
REQ-010 in_Thresh  input  $clog2(DEPTH)+1  FIFO-level interrupt threshold; 0 disables the level source.
REQ-011 out_Rd_Data  output  8  popped byte, held until the next pop.
REQ-012 out_Rd_Valid  output  1  one-cycle strobe marking out_Rd_Data updated.
REQ-013 out_Count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 out_Empty / out_Full  output  1 each  occupancy == 0 / occupancy == DEPTH.
REQ-015 out_Overrun  output  1  sticky flag: a byte was dropped.
REQ-016 out_Timeout  output  1  sticky flag: receive idle timeout occurred.
REQ-017 out_IRQ  output  1  registered interrupt request.

Function
REQ-018 State machine: DISABLED, ACTIVE; DISABLED -> ACTIVE when in_Enable=1; ACTIVE -> DISABLED when in_Enable=0.
REQ-019 On entry to DISABLED, flush in the same clock: pointers, count and timeout counter to 0, out_Timeout=0. out_Overrun and out_Rd_Data are retained.
REQ-020 While DISABLED: ignore in_RX_DV and in_Rd_En, keep out_Rd_Valid=0, out_IRQ=0.
REQ-021 Push in ACTIVE: in_RX_DV=1 and not full -> write in_RX_Byte at the write pointer, increment the pointer (mod DEPTH) and the count; visible in out_Count next cycle.
REQ-022 Push with FIFO full and no pop in the same cycle -> drop the byte, set out_Overrun=1 next cycle, leave FIFO contents unchanged.
REQ-023 Pop in ACTIVE: in_Rd_En=1 and not empty -> register out_Rd_Data from the read pointer, pulse out_Rd_Valid for exactly one cycle, increment the pointer (mod DEPTH), decrement the count; latency 1 clock.
REQ-024 Pop when empty -> ignored; no out_Rd_Valid, no underflow, out_Rd_Data unchanged.
REQ-025 Simultaneous push and pop, FIFO non-empty (including full) -> both occur, count unchanged, no overrun.
REQ-026 Simultaneous push and pop, FIFO empty -> push only; pop ignored.
REQ-027 Data order strictly FIFO across pointer wrap-around.
REQ-028 in_Clr_Ovr=1 clears out_Overrun next cycle. If it coincides with a new drop, set wins.
REQ-029 Timeout counter: cleared on any accepted push or pop and while the FIFO is empty; otherwise increments each clock.
REQ-030 When the timeout counter reaches TIMEOUT_CLKS-1, set out_Timeout=1 and hold the counter saturated.
REQ-031 out_Timeout clears on the next accepted pop or on flush; the counter then restarts.
REQ-032 out_IRQ (registered) = ACTIVE & ((in_Thresh!=0 & count>=in_Thresh) | out_Overrun | out_Timeout), evaluated on next-state values.
REQ-033 Counter and pointer widths are sized so no arithmetic overflows; count ranges 0..DEPTH inclusive.

Reset
REQ-034 On in_Reset=0, asynchronously: state=DISABLED, pointers/count/timeout counter=0, out_Rd_Data=8'h00, out_Rd_Valid=0, out_Overrun=0, out_Timeout=0, out_IRQ=0, out_Empty=1, out_Full=0.
REQ-035 Reset asserted mid-operation discards FIFO contents and any in-flight pop; no out_Rd_Valid pulse follows reset release.

Verification
REQ-036 Enable, push 8'hA5, 8'h3C, pop twice -> out_Rd_Data A5 then 3C, each with a one-cycle out_Rd_Valid one clock after in_Rd_En; out_Empty=1 afterwards.
REQ-037 DEPTH=4: push 5 bytes 01..05 without popping -> out_Full=1, out_Overrun=1, byte 05 dropped; pops return 01..04. in_Clr_Ovr -> out_Overrun=0.
REQ-038 FIFO full, push 8'h77 with simultaneous pop -> out_Count stays 4, no overrun; 8'h77 is popped last.
REQ-039 TIMEOUT_CLKS=10: push one byte and idle -> out_Timeout=1 and out_IRQ=1 after the 10th idle clock; one pop -> out_Timeout=0, out_IRQ=0.
REQ-040 in_Thresh=2: after the second push out_IRQ=1; drop in_Enable -> out_Count=0 and out_IRQ=0 next cycle, out_Overrun retained.
REQ-041 Assert in_Reset with 3 bytes queued and in_Rd_En high -> all outputs at reset values, no out_Rd_Valid after release.
